claim_visited: RTL and testbench

CLAIM_VISITED -- requirements
Module: claim_visited

---
 rtl/claim_visited.sv | 182 ++++++++++++++++++
 tb/tb_claim_visited.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/claim_visited.sv
// claim_visited: claims vertices in a one-bit-per-vertex visited store.
//   A request that finds its bit clear sets it and reports new=1. A request
//   that finds its bit set reports new=0. A request whose index is outside
//   the store reports err=1 without touching the store. A clear pulse wipes
//   the whole store and zeroes the claim counter.
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   vertex_*              request handshake (valid/ready)
//   clear_in              single-cycle wipe request
//   mem_*                 visited-store read strobe, write port, read return
//   result_*              one-cycle result strobe (vertex, new, err)
//   clear_done_out        one-cycle pulse after the last wipe write
//   claimed_count_out     saturating count of new claims
module claim_visited #(
  parameter int PROC_BITS = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [32+PROC_BITS-1:0] vertex_in,
  input  logic                   vertex_valid_in,
  output logic                   vertex_ready_out,
  input  logic                   clear_in,
  output logic [32+PROC_BITS-1:0] mem_addr_out,
  output logic                   mem_addr_valid_out,
  output logic                   mem_write_data_out,
  output logic                   mem_write_valid_out,
  input  logic                   mem_data_in,
  input  logic                   mem_valid_in,
  output logic [32+PROC_BITS-1:0] result_vertex_out,
  output logic                   result_new_out,
  output logic                   result_err_out,
  output logic                   result_valid_out,
  output logic                   clear_done_out,
  output logic [15:0]            claimed_count_out
);
  localparam int VW = 32 + PROC_BITS;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, WRITE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [VW-1:0]        vertex_q, vertex_d;
  logic [VW-1:0]        addr_q, addr_d;
  logic                 addr_valid_q, addr_valid_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 wr_data_q, wr_data_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_new_q, res_new_d;
  logic                 res_err_q, res_err_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic [15:0]          count_q, count_d;
  logic                 pend_q, pend_d;
  logic [ADDR_BITS-1:0] wipe_q, wipe_d;
  logic [ADDR_BITS-1:0] wipe_nxt;

  assign wipe_nxt = wipe_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    vertex_d     = vertex_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    wr_valid_d   = 1'b0;
    wr_data_d    = 1'b0;
    res_valid_d  = 1'b0;
    res_new_d    = res_new_q;
    res_err_d    = res_err_q;
    done_d       = 1'b0;
    count_d      = count_q;
    pend_d       = pend_q | clear_in;
    wipe_d       = wipe_q;

    case (state_q)
      IDLE: begin
        // A clear (pending or arriving now) pre-empts a request offered in
        // the same cycle; the requester keeps valid high and is served
        // after the wipe.
        if (pend_q || clear_in) begin
          state_d    = CLEAR;
          pend_d     = 1'b0;
          wipe_d     = '0;
          addr_d     = '0;
          wr_valid_d = 1'b1;
        end else if (vertex_valid_in && ready_q) begin
          vertex_d = vertex_in;
          if (|vertex_in[31:ADDR_BITS]) begin
            state_d     = RESP;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_new_d   = 1'b0;
          end else begin
            state_d      = ISSUE;
            addr_d       = vertex_in;
            addr_valid_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_valid_in) begin
          res_valid_d = 1'b1;
          res_err_d   = 1'b0;
          if (!mem_data_in) begin
            state_d    = WRITE;
            wr_valid_d = 1'b1;
            wr_data_d  = 1'b1;
            res_new_d  = 1'b1;
            count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          end else begin
            state_d   = RESP;
            res_new_d = 1'b0;
          end
        end
      end
      RESP:  state_d = IDLE;
      WRITE: state_d = IDLE;
      CLEAR: begin
        // wipe_q is the address being written this cycle
        if (wipe_q == {ADDR_BITS{1'b1}}) begin
          state_d = IDLE;
          done_d  = 1'b1;
          count_d = '0;
        end else begin
          wipe_d     = wipe_nxt;
          addr_d     = {{(VW-ADDR_BITS){1'b0}}, wipe_nxt};
          wr_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) && !pend_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      vertex_q     <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_new_q    <= 1'b0;
      res_err_q    <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      wipe_q       <= '0;
    end else begin
      state_q      <= state_d;
      vertex_q     <= vertex_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      res_valid_q  <= res_valid_d;
      res_new_q    <= res_new_d;
      res_err_q    <= res_err_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      wipe_q       <= wipe_d;
    end
  end

  assign vertex_ready_out    = ready_q;
  assign mem_addr_out        = addr_q;
  assign mem_addr_valid_out  = addr_valid_q;
  assign mem_write_data_out  = wr_data_q;
  assign mem_write_valid_out = wr_valid_q;
  assign result_vertex_out   = vertex_q;
  assign result_new_out      = res_new_q;
  assign result_err_out      = res_err_q;
  assign result_valid_out    = res_valid_q;
  assign clear_done_out      = done_q;
  assign claimed_count_out   = count_q;

endmodule

// File: tb/tb_claim_visited.sv
// Directed bench for claim_visited with a 2-cycle visited-store model.
module tb_claim_visited;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [35:0] vertex_in;
  logic        vertex_valid_in;
  logic        vertex_ready_out;
  logic        clear_in;
  logic [35:0] mem_addr_out;
  logic        mem_addr_valid_out;
  logic        mem_write_data_out;
  logic        mem_write_valid_out;
  logic        mem_data_in;
  logic        mem_valid_in;
  logic [35:0] result_vertex_out;
  logic        result_new_out;
  logic        result_err_out;
  logic        result_valid_out;
  logic        clear_done_out;
  logic [15:0] claimed_count_out;

  always #5 clk_in = ~clk_in;

  claim_visited #(.PROC_BITS(4), .ADDR_BITS(10)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .vertex_in(vertex_in), .vertex_valid_in(vertex_valid_in),
    .vertex_ready_out(vertex_ready_out), .clear_in(clear_in),
    .mem_addr_out(mem_addr_out), .mem_addr_valid_out(mem_addr_valid_out),
    .mem_write_data_out(mem_write_data_out), .mem_write_valid_out(mem_write_valid_out),
    .mem_data_in(mem_data_in), .mem_valid_in(mem_valid_in),
    .result_vertex_out(result_vertex_out), .result_new_out(result_new_out),
    .result_err_out(result_err_out), .result_valid_out(result_valid_out),
    .clear_done_out(clear_done_out), .claimed_count_out(claimed_count_out)
  );

  // store model: strobe in cycle n, data valid in cycle n+2
  logic [1023:0] vis = '0;
  logic        mem_en = 1'b1;
  logic        p1 = 1'b0;
  logic [9:0]  pa1 = '0;
  logic        m_valid = 1'b0;
  logic        m_data = 1'b0;
  logic        inj_valid = 1'b0;
  logic        inj_data = 1'b0;
  logic [35:0] last_wa = '0;
  logic        last_wd = 1'b0;
  logic [35:0] zw_exp = '0;
  int wr_cnt = 0, av_cnt = 0, res_cnt = 0, zw_cnt = 0, zw_bad = 0, both_cnt = 0;

  assign mem_valid_in = m_valid | inj_valid;
  assign mem_data_in  = m_valid ? m_data : inj_data;

  always @(posedge clk_in) begin
    p1      <= mem_addr_valid_out & mem_en;
    pa1     <= mem_addr_out[9:0];
    m_valid <= p1;
    m_data  <= vis[pa1];
    if (mem_write_valid_out) begin
      vis[mem_addr_out[9:0]] <= mem_write_data_out;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr_out;
      last_wd <= mem_write_data_out;
      if (!mem_write_data_out) begin
        if (mem_addr_out != zw_exp) zw_bad <= zw_bad + 1;
        zw_exp <= zw_exp + 36'd1;
        zw_cnt <= zw_cnt + 1;
      end
    end
    if (mem_addr_valid_out) av_cnt <= av_cnt + 1;
    if (result_valid_out) res_cnt <= res_cnt + 1;
    if (mem_addr_valid_out && mem_write_valid_out) both_cnt <= both_cnt + 1;
  end

  int total = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers v until accepted, then waits for the result strobe.
  // Called and returns at a falling edge.
  task automatic claim(input logic [35:0] v, output logic got, output logic rnew,
                       output logic rerr, output logic [35:0] rv);
    int n;
    got = 1'b0; rnew = 1'b0; rerr = 1'b0; rv = '0;
    vertex_in = v;
    vertex_valid_in = 1'b1;
    n = 0;
    while (!vertex_ready_out && n < 2000) begin @(negedge clk_in); n++; end
    @(negedge clk_in);
    vertex_valid_in = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      if (result_valid_out) begin
        got = 1'b1; rnew = result_new_out; rerr = result_err_out; rv = result_vertex_out;
      end else begin
        @(negedge clk_in); n++;
      end
    end
  endtask

  initial begin
    logic got, rnew, rerr;
    logic [35:0] rv;
    int wr0, av0, res0, n;

    rst_in = 1'b1; vertex_in = '0; vertex_valid_in = 1'b0; clear_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_ready", vertex_ready_out, 0);
    chk("rst_res_valid", result_valid_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_addr_valid", mem_addr_valid_out, 0);
    chk("rst_wr_valid", mem_write_valid_out, 0);
    chk("rst_count", claimed_count_out, 0);
    chk("rst_done", clear_done_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("ready_after_rst", vertex_ready_out, 1);

    // fresh claim of vertex 5, cycle-exact
    vertex_in = 36'd5; vertex_valid_in = 1'b1;
    @(negedge clk_in);                        // cycle 1
    vertex_valid_in = 1'b0;
    chk("c1_addr_valid", mem_addr_valid_out, 1);
    chk("c1_addr", mem_addr_out, 5);
    chk("c1_ready", vertex_ready_out, 0);
    @(negedge clk_in);                        // cycle 2
    chk("c2_addr_valid", mem_addr_valid_out, 0);
    @(negedge clk_in);                        // cycle 3
    chk("c3_res_valid", result_valid_out, 0);
    @(negedge clk_in);                        // cycle 4
    chk("c4_res_valid", result_valid_out, 1);
    chk("c4_new", result_new_out, 1);
    chk("c4_err", result_err_out, 0);
    chk("c4_vertex", result_vertex_out, 5);
    chk("c4_wr_valid", mem_write_valid_out, 1);
    chk("c4_wr_data", mem_write_data_out, 1);
    chk("c4_wr_addr", mem_addr_out, 5);
    @(negedge clk_in);                        // cycle 5
    chk("c5_res_valid", result_valid_out, 0);
    chk("c5_count", claimed_count_out, 1);
    chk("c5_wr_cnt", wr_cnt, 1);
    chk("c5_ready", vertex_ready_out, 1);

    // repeat claim of 5: already visited
    wr0 = wr_cnt;
    claim(36'd5, got, rnew, rerr, rv);
    chk("rep_got", got, 1);
    chk("rep_new", rnew, 0);
    chk("rep_err", rerr, 0);
    @(negedge clk_in);
    chk("rep_no_write", wr_cnt, wr0);
    chk("rep_count", claimed_count_out, 1);

    // out of range
    av0 = av_cnt;
    claim(36'h0_0000_0400, got, rnew, rerr, rv);
    chk("oor_got", got, 1);
    chk("oor_err", rerr, 1);
    chk("oor_new", rnew, 0);
    chk("oor_vertex", rv, 36'h0_0000_0400);
    @(negedge clk_in);
    chk("oor_no_read", av_cnt, av0);
    chk("oor_no_write", wr_cnt, wr0);

    // processor tag is carried to the store address
    claim(36'hA_0000_0009, got, rnew, rerr, rv);
    chk("tag_new", rnew, 1);
    @(negedge clk_in);
    chk("tag_wr_addr", last_wa, 36'hA_0000_0009);
    chk("tag_wr_data", last_wd, 1);
    chk("tag_count", claimed_count_out, 2);

    // clear and request together: wipe first, then claim 5 anew
    res0 = res_cnt;
    clear_in = 1'b1; vertex_in = 36'd5; vertex_valid_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    chk("clr_wr_valid", mem_write_valid_out, 1);
    chk("clr_wr_data", mem_write_data_out, 0);
    chk("clr_addr0", mem_addr_out, 0);
    chk("clr_addr_valid", mem_addr_valid_out, 0);
    chk("clr_ready", vertex_ready_out, 0);
    n = 0;
    while (!clear_done_out && n < 1100) begin @(negedge clk_in); n++; end
    chk("clr_done", clear_done_out, 1);
    chk("clr_count0", claimed_count_out, 0);
    chk("clr_zero_writes", zw_cnt, 1024);
    chk("clr_addr_order", zw_bad, 0);
    chk("clr_no_result", res_cnt, res0);
    claim(36'd5, got, rnew, rerr, rv);
    chk("post_clr_got", got, 1);
    chk("post_clr_new", rnew, 1);
    @(negedge clk_in);
    chk("post_clr_count", claimed_count_out, 1);

    // saturation at 16'hFFFF
    force dut.count_q = 16'hFFFF;
    @(negedge clk_in);
    release dut.count_q;
    @(negedge clk_in);
    claim(36'd7, got, rnew, rerr, rv);
    chk("sat_new", rnew, 1);
    @(negedge clk_in);
    chk("sat_count", claimed_count_out, 16'hFFFF);

    // reset during WAIT with a late read return
    mem_en = 1'b0;
    vertex_in = 36'd3; vertex_valid_in = 1'b1;
    @(negedge clk_in);                        // ISSUE
    vertex_valid_in = 1'b0;
    chk("rw_addr_valid", mem_addr_valid_out, 1);
    @(negedge clk_in);                        // WAIT
    rst_in = 1'b1;
    wr0 = wr_cnt; res0 = res_cnt;
    inj_valid = 1'b1; inj_data = 1'b0;
    @(negedge clk_in);
    chk("rw_ready_in_rst", vertex_ready_out, 0);
    chk("rw_count_rst", claimed_count_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    inj_valid = 1'b0;
    chk("rw_ready_after", vertex_ready_out, 1);
    repeat (3) @(negedge clk_in);
    chk("rw_no_write", wr_cnt, wr0);
    chk("rw_no_result", res_cnt, res0);

    chk("never_both_strobes", both_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
